// File: rtl/avalon_bus_arbiter.sv
// Two-port Avalon-MM arbiter for the SDRAM master: VGA fetch (port 0) has fixed priority,
// the render engine (port 1) gets an anti-starvation override, and read data is steered by an owner-tag FIFO.
module avalon_bus_arbiter #(
    parameter int ADDR_W       = 26,
    parameter int DATA_W       = 32,
    parameter int MAX_PENDING  = 8,
    parameter int STARVE_LIMIT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_read,
    input  logic [ADDR_W-1:0] m0_address,
    output logic              m0_waitrequest,
    output logic              m0_readdatavalid,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic              m1_readdatavalid,
    output logic [DATA_W-1:0] readdata,
    output logic              master_read,
    output logic              master_write,
    output logic [ADDR_W-1:0] master_address,
    output logic [DATA_W-1:0] master_writedata,
    input  logic              master_waitrequest,
    input  logic              master_readdatavalid,
    input  logic [DATA_W-1:0] bus_data,
    output logic              err_orphan
);
    localparam int PW = $clog2(MAX_PENDING);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [MAX_PENDING-1:0] tag_mem;
    logic [PW-1:0]          wr_ptr, rd_ptr;
    logic [PW:0]            count;
    logic                   lock, lock_owner;
    logic [SW-1:0]          starve_cnt;

    logic full, empty, elig0, elig1, req1;
    logic grant_vld, grant, sel0, sel1;
    logic cmd, accept, push, pop, head;

    assign full  = (count == (PW+1)'(MAX_PENDING));
    assign empty = (count == '0);
    assign req1  = m1_read | m1_write;

    // Priority is resolved among eligible requesters, so a read stalled on a
    // full tag FIFO never blocks a write from the other port.
    assign elig0 = m0_read & ~full;
    assign elig1 = m1_write | (m1_read & ~full);

    always_comb begin
        grant_vld = 1'b0;
        grant     = 1'b0;
        if (!reset) begin
            grant_vld = 1'b0;
        end else if (lock) begin
            grant_vld = 1'b1;
            grant     = lock_owner;
        end else if (starve_cnt == SW'(STARVE_LIMIT) && elig1) begin
            grant_vld = 1'b1;
            grant     = 1'b1;
        end else if (elig0) begin
            grant_vld = 1'b1;
        end else if (elig1) begin
            grant_vld = 1'b1;
            grant     = 1'b1;
        end
    end

    assign sel0 = grant_vld & ~grant;
    assign sel1 = grant_vld & grant;

    assign master_read      = (sel0 & m0_read) | (sel1 & m1_read);
    assign master_write     = sel1 & m1_write;
    assign master_address   = sel0 ? m0_address : (sel1 ? m1_address : '0);
    assign master_writedata = sel1 ? m1_writedata : '0;

    assign m0_waitrequest = ~sel0 | master_waitrequest;
    assign m1_waitrequest = ~sel1 | master_waitrequest;

    assign cmd    = master_read | master_write;
    assign accept = cmd & ~master_waitrequest;
    assign push   = accept & master_read;
    assign pop    = reset & master_readdatavalid & ~empty;
    assign head   = tag_mem[rd_ptr];

    assign m0_readdatavalid = pop & ~head;
    assign m1_readdatavalid = pop & head;
    assign readdata         = bus_data;

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            lock       <= 1'b0;
            lock_owner <= 1'b0;
            starve_cnt <= '0;
            err_orphan <= 1'b0;
        end else begin
            // Hold the owner while the bus stalls so the command stays stable.
            lock       <= cmd & master_waitrequest;
            lock_owner <= grant;
            if (push) begin
                tag_mem[wr_ptr] <= grant;
                wr_ptr          <= wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
            if (master_readdatavalid && empty)
                err_orphan <= 1'b1;
            if (!req1 || (accept && grant))
                starve_cnt <= '0;
            else if (accept && !grant && starve_cnt != SW'(STARVE_LIMIT))
                starve_cnt <= starve_cnt + SW'(1);
        end
    end
endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// Bench for avalon_bus_arbiter: directed scenarios followed by random traffic, all
// compared cycle by cycle against a queue-based reference of the arbitration rules.
module tb_avalon_bus_arbiter;
    localparam int AW = 26, DW = 32, DEPTH = 8, LIMIT = 16;

    logic clk = 1'b0;
    logic reset;
    logic m0_read, m1_read, m1_write;
    logic [AW-1:0] m0_address, m1_address;
    logic [DW-1:0] m1_writedata, bus_data;
    logic master_waitrequest, master_readdatavalid;
    logic m0_waitrequest, m0_readdatavalid, m1_waitrequest, m1_readdatavalid;
    logic master_read, master_write, err_orphan;
    logic [AW-1:0] master_address;
    logic [DW-1:0] master_writedata, readdata;

    always #5 clk = ~clk;

    avalon_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_PENDING(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .m0_read(m0_read), .m0_address(m0_address),
        .m0_waitrequest(m0_waitrequest), .m0_readdatavalid(m0_readdatavalid),
        .m1_read(m1_read), .m1_write(m1_write), .m1_address(m1_address),
        .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
        .m1_readdatavalid(m1_readdatavalid), .readdata(readdata),
        .master_read(master_read), .master_write(master_write),
        .master_address(master_address), .master_writedata(master_writedata),
        .master_waitrequest(master_waitrequest), .master_readdatavalid(master_readdatavalid),
        .bus_data(bus_data), .err_orphan(err_orphan)
    );

    int n_cmp = 0, n_err = 0;
    string step = "init";
    // Reference state: owners of outstanding reads in issue order, etc.
    int q[$];
    bit lk = 0;
    int lown = 0;
    int st = 0;
    bit orph = 0;
    bit ew0, ew1, o_mr, o_mw, o_v0, o_v1, o_w0, o_err;
    logic [AW-1:0] o_addr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s/%s observed=%0h expected=%0h", step, tag, obs, exp);
        end
    endtask

    task automatic cyc(input bit rst, input bit r0, input logic [AW-1:0] a0,
                       input bit r1, input bit w1, input logic [AW-1:0] a1,
                       input logic [DW-1:0] wd, input bit mwt, input bit mrdv,
                       input logic [DW-1:0] bd);
        int g;
        bit full, e0, e1, elig, emr, emw, acc;
        logic [AW-1:0] eaddr;
        logic [DW-1:0] ewd;
        reset = rst; m0_read = r0; m0_address = a0; m1_read = r1; m1_write = w1;
        m1_address = a1; m1_writedata = wd; master_waitrequest = mwt;
        master_readdatavalid = mrdv; bus_data = bd;
        #2;
        full = (q.size() >= DEPTH);
        e0 = r0 && !full;
        e1 = w1 || (r1 && !full);
        g = -1; elig = 0;
        if (rst) begin
            if (lk) begin g = lown; elig = (g == 0) ? r0 : (r1 || w1); end
            else if (st == LIMIT && e1) g = 1;
            else if (e0) g = 0;
            else if (e1) g = 1;
            if (!lk) elig = (g >= 0);
        end
        emr   = elig && (g == 0 || r1);
        emw   = elig && g == 1 && w1;
        eaddr = !elig ? '0 : (g == 0 ? a0 : a1);
        ewd   = (elig && g == 1) ? wd : '0;
        ew0   = !(elig && g == 0) || mwt;
        ew1   = !(elig && g == 1) || mwt;
        chk("master_read", master_read, emr);
        chk("master_write", master_write, emw);
        chk("master_address", master_address, eaddr);
        chk("master_writedata", master_writedata, ewd);
        chk("m0_waitrequest", m0_waitrequest, ew0);
        chk("m1_waitrequest", m1_waitrequest, ew1);
        chk("m0_readdatavalid", m0_readdatavalid, rst && mrdv && q.size() > 0 && q[0] == 0);
        chk("m1_readdatavalid", m1_readdatavalid, rst && mrdv && q.size() > 0 && q[0] == 1);
        chk("readdata", readdata, bd);
        chk("err_orphan", err_orphan, orph);
        o_mr = master_read; o_mw = master_write; o_addr = master_address;
        o_v0 = m0_readdatavalid; o_v1 = m1_readdatavalid; o_w0 = m0_waitrequest;
        o_err = err_orphan;
        if (!rst) begin
            q.delete(); lk = 0; st = 0; orph = 0;
        end else begin
            acc = elig && !mwt;
            if (mrdv) begin
                if (q.size() > 0) void'(q.pop_front());
                else orph = 1;
            end
            if (acc && emr) q.push_back(g);
            if (!(r1 || w1) || (acc && g == 1)) st = 0;
            else if (acc && g == 0 && st < LIMIT) st++;
            lk = elig && mwt;
            lown = g;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit mrdv);
        cyc(1, 0, '0, 0, 0, '0, '0, 0, mrdv, 32'h0);
    endtask

    task automatic drain();
        for (int k = 0; k < 2 * DEPTH && q.size() > 0; k++) idle(1);
        chk("drained", q.size(), 0);
    endtask

    initial begin
        bit r0, r1, w1, mwt, mrdv, got;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] wd;
        bit [3:0] pat;
        int cnt, dens, k;

        reset = 0; m0_read = 0; m1_read = 0; m1_write = 0; m0_address = '0;
        m1_address = '0; m1_writedata = '0; master_waitrequest = 0;
        master_readdatavalid = 0; bus_data = '0;
        @(posedge clk); #1;

        step = "reset";
        cyc(0, 1, 26'h10, 0, 1, 26'h20, 32'h1, 0, 1, 32'h0);
        chk("rst_wait0", o_w0, 1);
        chk("rst_read", o_mr, 0);
        idle(0);

        step = "t1";
        cyc(1, 1, 26'h100, 0, 0, '0, '0, 0, 0, 32'h0);
        chk("t1_read", o_mr, 1);
        chk("t1_wait0", o_w0, 0);
        idle(0); idle(0);
        cyc(1, 0, '0, 0, 0, '0, '0, 0, 1, 32'hDEADBEEF);
        chk("t1_v0", o_v0, 1);
        chk("t1_v1", o_v1, 0);

        step = "t2";
        for (int i = 0; i < 5; i++) begin
            cyc(1, 1, 26'h200, 0, 1, 26'h2ff, 32'h22, (i < 4), 0, 32'h0);
            chk("t2_addr", o_addr, 26'h200);
            chk("t2_wait1", m1_waitrequest, 1);
        end
        cyc(1, 0, '0, 0, 1, 26'h2ff, 32'h22, 0, 0, 32'h0);
        chk("t2_p1_write", o_mw, 1);
        drain();

        step = "t3";
        cnt = 0; got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            cyc(1, 1, AW'(26'h300 + i), 0, 1, 26'h3ff, 32'h33, 0, q.size() > 0, 32'h5);
            if (o_mw) got = 1;
            else if (o_mr) cnt++;
        end
        chk("t3_got", got, 1);
        chk("t3_count", cnt, LIMIT);
        cyc(1, 1, 26'h350, 0, 1, 26'h3ff, 32'h33, 0, q.size() > 0, 32'h5);
        chk("t3_p0_again", o_mr, 1);
        drain();

        step = "t4";
        cyc(1, 1, 26'h400, 0, 0, '0, '0, 0, 0, 32'h0);
        cyc(1, 0, '0, 1, 0, 26'h401, '0, 0, 0, 32'h0);
        cyc(1, 0, '0, 1, 0, 26'h402, '0, 0, 0, 32'h0);
        cyc(1, 1, 26'h403, 0, 0, '0, '0, 0, 0, 32'h0);
        pat = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, '0, 0, 0, '0, '0, 0, 1, 32'(i));
            chk("t4_v1", o_v1, pat[i]);
            chk("t4_v0", o_v0, !pat[i]);
        end

        step = "t5";
        for (int i = 0; i < DEPTH; i++) cyc(1, 1, AW'(26'h500 + i), 0, 0, '0, '0, 0, 0, 32'h0);
        cyc(1, 1, 26'h508, 0, 1, 26'h5ff, 32'h55, 0, 0, 32'h0);
        chk("t5_wait0", o_w0, 1);
        chk("t5_noread", o_mr, 0);
        chk("t5_write", o_mw, 1);
        cyc(1, 1, 26'h508, 0, 0, '0, '0, 0, 1, 32'h0);
        chk("t5_popcyc_wait0", o_w0, 1);
        cyc(1, 1, 26'h508, 0, 0, '0, '0, 0, 0, 32'h0);
        chk("t5_issue", o_mr, 1);
        drain();

        step = "t6";
        idle(1);
        idle(0);
        chk("t6_err", o_err, 1);
        idle(0);
        chk("t6_err_held", o_err, 1);
        cyc(0, 0, '0, 0, 0, '0, '0, 0, 0, 32'h0);
        idle(0);
        chk("t6_err_clr", o_err, 0);

        step = "rand";
        r0 = 0; r1 = 0; w1 = 0; a0 = '0; a1 = '0; wd = '0;
        ew0 = 1; ew1 = 1;
        for (int i = 0; i < 2000; i++) begin
            dens = (i < 1000) ? 9 : 5;
            if (!(ew0 && r0)) begin
                r0 = ($urandom_range(0, 9) < dens);
                a0 = AW'($urandom);
            end
            if (!(ew1 && (r1 || w1))) begin
                k = $urandom_range(0, 3);
                r1 = (k == 2); w1 = (k == 3);
                a1 = AW'($urandom); wd = $urandom;
            end
            mwt  = ($urandom_range(0, 9) < 3);
            mrdv = (q.size() > 0) && ($urandom_range(0, 9) < 4);
            cyc(1, r0, a0, r1, w1, a1, wd, mwt, mrdv, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
